// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU-control, FSM-state and instruction-class definitions
// for the multi-cycle control FSM and its decoder.
package ctrl_pkg;

  localparam int OP_ADD      = 0;
  localparam int OP_SUB      = 1;
  localparam int OP_MUL      = 2;
  localparam int OP_AND      = 3;
  localparam int OP_OR       = 4;
  localparam int OP_ADDI     = 5;
  localparam int OP_LDB      = 10;
  localparam int OP_LDW      = 11;
  localparam int OP_STB      = 12;
  localparam int OP_STW      = 13;
  localparam int OP_MOV      = 14;
  localparam int OP_BEQ      = 20;
  localparam int OP_JUMP     = 21;
  localparam int OP_TLBWRITE = 30;
  localparam int OP_IRET     = 31;

  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB, TRAP} state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_IMM, CLS_LOAD, CLS_STORE, CLS_BR, CLS_JMP, CLS_SYS, CLS_ILL
  } instr_class_t;

endpackage

// File: rtl/control_fsm_if.sv
// Fetch/datapath-facing bundle of the control FSM: instruction handshake in,
// memory/ALU status in, datapath strobes out.
interface control_fsm_if #(
  parameter int OP_W       = 6,
  parameter int ALU_CTRL_W = 4
);
  logic                  instr_valid;
  logic                  instr_ready;
  logic [OP_W-1:0]       op;
  logic                  alu_zero;
  logic                  mem_ready;
  logic                  reg_dest;
  logic                  alu_src;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  mem_read;
  logic                  mem_write;
  logic                  mem_byte;
  logic                  mem_to_reg;
  logic                  reg_write;
  logic                  branch_taken;
  logic                  jump;
  logic                  tlb_write;
  logic                  iret;
  logic                  instr_done;
  logic                  illegal_op;
  logic                  mem_err;

  modport master (
    output instr_valid, op, alu_zero, mem_ready,
    input  instr_ready, reg_dest, alu_src, alu_ctrl, mem_read, mem_write, mem_byte,
           mem_to_reg, reg_write, branch_taken, jump, tlb_write, iret, instr_done,
           illegal_op, mem_err
  );

  modport slave (
    input  instr_valid, op, alu_zero, mem_ready,
    output instr_ready, reg_dest, alu_src, alu_ctrl, mem_read, mem_write, mem_byte,
           mem_to_reg, reg_write, branch_taken, jump, tlb_write, iret, instr_done,
           illegal_op, mem_err
  );
endinterface

// File: rtl/control_decode.sv
// Pure combinational opcode classifier: op -> class, ALU controls, byte flag, legality.
// Zero latency; no handshake.
module control_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W       = 6,
  parameter int ALU_CTRL_W = 4
) (
  input  logic [OP_W-1:0]       op,
  output instr_class_t          cls,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  alu_src,
  output logic                  reg_dest,
  output logic                  mem_byte,
  output logic                  legal
);

  always_comb begin
    cls      = CLS_ILL;
    alu_ctrl = '0;
    alu_src  = 1'b0;
    reg_dest = 1'b0;
    mem_byte = 1'b0;
    case (int'(op))
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR: begin
        cls      = CLS_R;
        alu_ctrl = ALU_CTRL_W'(op);
        reg_dest = 1'b1;
      end
      OP_ADDI: begin
        cls      = CLS_IMM;
        alu_ctrl = ALU_CTRL_W'(ALU_ADD);
        alu_src  = 1'b1;
      end
      OP_LDB, OP_LDW: begin
        cls      = CLS_LOAD;
        alu_ctrl = ALU_CTRL_W'(ALU_ADD);
        alu_src  = 1'b1;
        mem_byte = (int'(op) == OP_LDB);
      end
      // MOV travels the store path: address add, then a memory write.
      OP_STB, OP_STW, OP_MOV: begin
        cls      = CLS_STORE;
        alu_ctrl = ALU_CTRL_W'(ALU_ADD);
        alu_src  = 1'b1;
        mem_byte = (int'(op) == OP_STB);
      end
      OP_BEQ: begin
        cls      = CLS_BR;
        alu_ctrl = ALU_CTRL_W'(ALU_SUB);
      end
      OP_JUMP:               cls = CLS_JMP;
      OP_TLBWRITE, OP_IRET:  cls = CLS_SYS;
      default:               cls = CLS_ILL;
    endcase
    legal = (cls != CLS_ILL);
  end

endmodule

// File: rtl/control_fsm.sv
// Moore control FSM: accepts one opcode in IDLE, sequences DECODE/EXEC/MEM/WB/TRAP.
// Latency 2-3 cycles plus memory waits; instr_ready only in IDLE, MEM stalls on mem_ready.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int OP_W       = 6,
  parameter int ALU_CTRL_W = 4,
  parameter int MEM_TMO    = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  control_fsm_if.slave  bus
);

  localparam int TMO_W = $clog2(MEM_TMO + 1);

  state_t                state, state_nxt;
  logic [OP_W-1:0]       op_q, op_nxt;
  logic [TMO_W-1:0]      tmo_cnt, tmo_nxt;
  logic                  cause_mem, cause_nxt;
  logic                  tmo_hit;

  instr_class_t          dec_cls;
  logic [ALU_CTRL_W-1:0] dec_alu_ctrl;
  logic                  dec_alu_src;
  logic                  dec_reg_dest;
  logic                  dec_mem_byte;
  logic                  dec_legal;

  control_decode #(
    .OP_W       (OP_W),
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_decode (
    .op       (op_q),
    .cls      (dec_cls),
    .alu_ctrl (dec_alu_ctrl),
    .alu_src  (dec_alu_src),
    .reg_dest (dec_reg_dest),
    .mem_byte (dec_mem_byte),
    .legal    (dec_legal)
  );

  assign tmo_hit = (tmo_cnt == TMO_W'(MEM_TMO - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      tmo_cnt   <= '0;
      cause_mem <= 1'b0;
    end else begin
      state     <= state_nxt;
      op_q      <= op_nxt;
      tmo_cnt   <= tmo_nxt;
      cause_mem <= cause_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    op_nxt           = op_q;
    tmo_nxt          = tmo_cnt;
    cause_nxt        = cause_mem;
    bus.instr_ready  = 1'b0;
    bus.reg_dest     = 1'b0;
    bus.alu_src      = 1'b0;
    bus.alu_ctrl     = '0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_byte     = 1'b0;
    bus.mem_to_reg   = 1'b0;
    bus.reg_write    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.jump         = 1'b0;
    bus.tlb_write    = 1'b0;
    bus.iret         = 1'b0;
    bus.instr_done   = 1'b0;
    bus.illegal_op   = 1'b0;
    bus.mem_err      = 1'b0;

    case (state)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          op_nxt    = bus.op;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        if (!dec_legal) begin
          cause_nxt = 1'b0;
          state_nxt = TRAP;
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        bus.alu_ctrl = dec_alu_ctrl;
        bus.alu_src  = dec_alu_src;
        bus.reg_dest = dec_reg_dest;
        case (dec_cls)
          CLS_R, CLS_IMM:     state_nxt = WB;
          CLS_LOAD, CLS_STORE: begin
            tmo_nxt   = '0;
            state_nxt = MEM;
          end
          CLS_BR: begin
            bus.branch_taken = bus.alu_zero;
            bus.instr_done   = 1'b1;
            state_nxt        = IDLE;
          end
          CLS_JMP: begin
            bus.jump       = 1'b1;
            bus.instr_done = 1'b1;
            state_nxt      = IDLE;
          end
          CLS_SYS: begin
            bus.tlb_write  = (int'(op_q) == OP_TLBWRITE);
            bus.iret       = (int'(op_q) == OP_IRET);
            bus.jump       = (int'(op_q) == OP_IRET);
            bus.instr_done = 1'b1;
            state_nxt      = IDLE;
          end
          default:            state_nxt = IDLE;
        endcase
      end
      MEM: begin
        bus.mem_read  = (dec_cls == CLS_LOAD);
        bus.mem_write = (dec_cls == CLS_STORE);
        bus.mem_byte  = dec_mem_byte;
        // A completion on the expiry cycle still retires the access.
        if (bus.mem_ready) begin
          if (dec_cls == CLS_LOAD) begin
            state_nxt = WB;
          end else begin
            bus.instr_done = 1'b1;
            state_nxt      = IDLE;
          end
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
          if (tmo_hit) begin
            cause_nxt = 1'b1;
            state_nxt = TRAP;
          end
        end
      end
      WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = (dec_cls == CLS_LOAD);
        bus.instr_done = 1'b1;
        state_nxt      = IDLE;
      end
      TRAP: begin
        bus.illegal_op = !cause_mem;
        bus.mem_err    = cause_mem;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Randomized bench for control_fsm: a driver expands each opcode into its expected per-cycle
// output trace (scoreboard queue); a separate monitor compares every cycle against it.
module tb_control_fsm;

  localparam int MEM_TMO = 15;

  localparam int C_R = 0, C_IMM = 1, C_LOAD = 2, C_STORE = 3, C_BR = 4, C_JMP = 5, C_SYS = 6, C_ILL = 7;
  localparam int P_DEC = 0, P_EXEC = 1, P_MEM = 2, P_WB = 3, P_TRI = 4, P_TRM = 5;

  typedef struct packed {
    logic       instr_ready;
    logic       reg_dest;
    logic       alu_src;
    logic [3:0] alu_ctrl;
    logic       mem_read;
    logic       mem_write;
    logic       mem_byte;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch_taken;
    logic       jump;
    logic       tlb_write;
    logic       iret;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_err;
  } out_t;

  typedef struct {
    int    cyc;
    out_t  v;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  control_fsm_if #(.OP_W(6), .ALU_CTRL_W(4)) bus ();

  control_fsm #(.OP_W(6), .ALU_CTRL_W(4), .MEM_TMO(MEM_TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic int cls_of(input int o);
    if (o >= 0 && o <= 4)        return C_R;
    if (o == 5)                  return C_IMM;
    if (o == 10 || o == 11)      return C_LOAD;
    if (o >= 12 && o <= 14)      return C_STORE;
    if (o == 20)                 return C_BR;
    if (o == 21)                 return C_JMP;
    if (o == 30 || o == 31)      return C_SYS;
    return C_ILL;
  endfunction

  function automatic out_t idle_v();
    out_t o;
    o = '0;
    o.instr_ready = 1'b1;
    return o;
  endfunction

  task automatic push(input out_t v, input string tag);
    exp_t e;
    e.cyc = cyc;
    e.v   = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Inputs the FSM must ignore in the current cycle get random values.
  task automatic junk();
    bus.instr_valid = 1'($urandom_range(0, 1));
    bus.op          = 6'($urandom);
    bus.mem_ready   = 1'($urandom_range(0, 1));
    bus.alu_zero    = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_gap(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst_n = 1'b1;
      junk();
      bus.instr_valid = 1'b0;
      push(idle_v(), "idle");
    end
  endtask

  // w: cycles of mem_ready=0 before the completing cycle (>= MEM_TMO means never).
  // z: forced alu_zero in EXEC, or -1 for random. abort_at: phase index that gets a reset.
  task automatic do_instr(input int o, input int w, input int z, input int abort_at);
    int    ph[$];
    int    cls;
    int    nmem;
    int    mi;
    out_t  e;
    string tag;
    tag = $sformatf("op%0d_w%0d", o, w);
    cls = cls_of(o);
    ph.push_back(P_DEC);
    if (cls == C_ILL) begin
      ph.push_back(P_TRI);
    end else begin
      ph.push_back(P_EXEC);
      if (cls == C_R || cls == C_IMM) begin
        ph.push_back(P_WB);
      end else if (cls == C_LOAD || cls == C_STORE) begin
        nmem = (w < MEM_TMO) ? w + 1 : MEM_TMO;
        for (int k = 0; k < nmem; k++) ph.push_back(P_MEM);
        if (w >= MEM_TMO)      ph.push_back(P_TRM);
        else if (cls == C_LOAD) ph.push_back(P_WB);
      end
    end

    @(negedge clk);
    rst_n = 1'b1;
    junk();
    bus.instr_valid = 1'b1;
    bus.op          = 6'(o);
    push(idle_v(), {tag, "_accept"});

    mi = 0;
    for (int i = 0; i < ph.size(); i++) begin
      @(negedge clk);
      junk();
      e = '0;
      if (i == abort_at) rst_n = 1'b0;
      case (ph[i])
        P_EXEC: begin
          if (z >= 0) bus.alu_zero = z[0];
          e.alu_ctrl = (o <= 4) ? 4'(o) : ((o == 20) ? 4'd1 : 4'd0);
          e.alu_src  = (o == 5) || (o >= 10 && o <= 14);
          e.reg_dest = (o <= 4);
          if (cls == C_BR) begin
            e.branch_taken = bus.alu_zero;
            e.instr_done   = 1'b1;
          end
          if (cls == C_JMP) begin
            e.jump       = 1'b1;
            e.instr_done = 1'b1;
          end
          if (cls == C_SYS) begin
            e.tlb_write  = (o == 30);
            e.iret       = (o == 31);
            e.jump       = (o == 31);
            e.instr_done = 1'b1;
          end
        end
        P_MEM: begin
          bus.mem_ready = (mi == w);
          e.mem_read    = (cls == C_LOAD);
          e.mem_write   = (cls == C_STORE);
          e.mem_byte    = (o == 10 || o == 12);
          e.instr_done  = (cls == C_STORE) && (mi == w);
          mi++;
        end
        P_WB: begin
          e.reg_write  = 1'b1;
          e.mem_to_reg = (cls == C_LOAD);
          e.instr_done = 1'b1;
        end
        P_TRI:   e.illegal_op = 1'b1;
        P_TRM:   e.mem_err    = 1'b1;
        default: e = '0;
      endcase
      push(e, $sformatf("%s_ph%0d", tag, i));
      if (i == abort_at) break;
    end
  endtask

  // Monitor: compares the DUT outputs of every cycle that has a scoreboard entry.
  initial begin
    out_t a;
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      a.instr_ready  = bus.instr_ready;
      a.reg_dest     = bus.reg_dest;
      a.alu_src      = bus.alu_src;
      a.alu_ctrl     = bus.alu_ctrl;
      a.mem_read     = bus.mem_read;
      a.mem_write    = bus.mem_write;
      a.mem_byte     = bus.mem_byte;
      a.mem_to_reg   = bus.mem_to_reg;
      a.reg_write    = bus.reg_write;
      a.branch_taken = bus.branch_taken;
      a.jump         = bus.jump;
      a.tlb_write    = bus.tlb_write;
      a.iret         = bus.iret;
      a.instr_done   = bus.instr_done;
      a.illegal_op   = bus.illegal_op;
      a.mem_err      = bus.mem_err;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL %s cyc=%0d: entry never sampled, expected=%h", e.tag, e.cyc, e.v);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if (a !== e.v) begin
          failures++;
          $display("FAIL %s cyc=%0d: got=%h expected=%h", e.tag, cyc, a, e.v);
        end
      end
    end
  end

  initial begin
    int o;
    int w;
    int ab;
    int legal_ops[15] = '{0, 1, 2, 3, 4, 5, 10, 11, 12, 13, 14, 20, 21, 30, 31};

    rst_n           = 1'b0;
    bus.instr_valid = 1'b1;
    bus.op          = 6'd0;
    bus.mem_ready   = 1'b0;
    bus.alu_zero    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      push(idle_v(), "reset");
    end

    do_instr(0, 0, -1, -1);
    do_instr(1, 0, -1, -1);
    idle_gap(1);
    do_instr(11, 4, -1, -1);
    do_instr(12, 0, -1, -1);
    do_instr(20, 0, 1, -1);
    do_instr(20, 0, 0, -1);
    do_instr(10, 100, -1, -1);
    do_instr(10, 14, -1, -1);
    do_instr(13, 14, -1, -1);
    do_instr(13, 100, -1, -1);
    do_instr(7, 0, -1, -1);
    do_instr(11, 100, -1, 4);
    do_instr(14, 2, -1, -1);
    do_instr(5, 0, -1, -1);
    do_instr(2, 0, -1, -1);
    do_instr(3, 0, -1, -1);
    do_instr(4, 0, -1, -1);
    do_instr(21, 0, -1, -1);
    do_instr(30, 0, -1, -1);
    do_instr(31, 0, -1, -1);
    do_instr(63, 0, -1, -1);
    idle_gap(2);

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) < 7) o = legal_ops[$urandom_range(0, 14)];
      else                          o = $urandom_range(0, 63);
      if ($urandom_range(0, 4) == 0) w = $urandom_range(10, 20);
      else                           w = $urandom_range(0, 3);
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 6) : -1;
      do_instr(o, w, -1, ab);
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
    end

    idle_gap(3);
    #5;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got=%0d pending entries expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
